// File: rtl/bus_trace_buffer.sv
// Circular CPU-bus trace buffer: arm, trigger on address, capture POST_COUNT more, freeze, read out oldest-first.
// Optional macro BUS_TRACE_PC_EN adds PC capture and read-out on o_entry_PC.
module bus_trace_buffer #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned POST_COUNT = 8
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [31:0]              i_bus_address,
  input  logic [31:0]              i_bus_data,
  input  logic                     i_bus_DV,
  input  logic                     i_write_notread,
  input  logic [2:0]               i_bhw,
  input  logic [31:0]              i_PC,
  input  logic                     i_trig_en,
  input  logic [31:0]              i_trig_address,
  input  logic                     i_rd_en,
  output logic [31:0]              o_entry_address,
  output logic [31:0]              o_entry_data,
  output logic [31:0]              o_entry_PC,
  output logic [3:0]               o_entry_ctrl,
  output logic                     o_rd_DV,
  output logic [1:0]               o_state,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    POST   = 2'd1,
    FROZEN = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] address;
    logic [31:0] data;
    logic [3:0]  ctrl;
  } entry_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_idx;
  logic [CW-1:0]   count;
  logic [CW-1:0]   post_cnt;
  entry_t          mem [DEPTH];

  logic capture, trig_hit, rd_fire, last_read, post_done;

  assign capture   = i_bus_DV && (state != FROZEN);
  assign trig_hit  = i_bus_DV && i_trig_en && (i_bus_address == i_trig_address);
  assign rd_fire   = (state == FROZEN) && i_rd_en && (count != '0);
  assign last_read = rd_fire && (count == CW'(1));
  assign post_done = CW'(post_cnt + CW'(1)) == CW'(POST_COUNT);
  // Oldest entry sits count slots behind the write pointer; a full buffer aliases to wr_ptr.
  assign rd_idx    = AW'(wr_ptr - AW'(count));

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= ARMED;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ARMED:   if (trig_hit) state_nxt = (POST_COUNT == 0) ? FROZEN : POST;
      POST:    if (capture && post_done) state_nxt = FROZEN;
      FROZEN:  if (last_read) state_nxt = ARMED;
      default: state_nxt = ARMED;
    endcase
  end

  // Pointers, occupancy, post counter and read-out registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr          <= '0;
      count           <= '0;
      post_cnt        <= '0;
      o_rd_DV         <= 1'b0;
      o_entry_address <= '0;
      o_entry_data    <= '0;
      o_entry_ctrl    <= '0;
    end else begin
      o_rd_DV <= rd_fire;
      if (capture) begin
        wr_ptr <= AW'(wr_ptr + AW'(1));
        if (count != CW'(DEPTH)) count <= CW'(count + CW'(1));
        if (state == POST) post_cnt <= CW'(post_cnt + CW'(1));
      end
      if (rd_fire) begin
        o_entry_address <= mem[rd_idx].address;
        o_entry_data    <= mem[rd_idx].data;
        o_entry_ctrl    <= mem[rd_idx].ctrl;
        if (last_read) begin
          wr_ptr   <= '0;
          post_cnt <= '0;
          count    <= '0;
        end else begin
          count <= CW'(count - CW'(1));
        end
      end
    end
  end

  // Trace storage, not cleared by reset
  always_ff @(posedge i_clk) begin
    if (capture && !i_reset)
      mem[wr_ptr] <= '{address: i_bus_address, data: i_bus_data,
                       ctrl: {i_write_notread, i_bhw}};
  end

`ifdef BUS_TRACE_PC_EN
  logic [31:0] mem_pc [DEPTH];

  always_ff @(posedge i_clk) begin
    if (capture && !i_reset) mem_pc[wr_ptr] <= i_PC;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)      o_entry_PC <= '0;
    else if (rd_fire) o_entry_PC <= mem_pc[rd_idx];
  end
`else
  logic unused_pc;
  assign unused_pc  = ^i_PC;
  assign o_entry_PC = '0;
`endif

  assign o_state = state;
  assign o_count = count;

endmodule

// File: tb/tb_bus_trace_buffer.sv
// Directed bench for bus_trace_buffer: per-cycle vector table plus trigger/freeze/read-out sequences.
module tb_bus_trace_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = '0, data = '0, pc = '0, trig_addr = '0;
  logic        dv = 1'b0, we = 1'b0, trig_en = 1'b0, rd = 1'b0;
  logic [2:0]  bhw = '0;

  logic [31:0] a_addr, a_data, a_pc;
  logic [3:0]  a_ctrl;
  logic        a_rd_dv;
  logic [1:0]  a_state;
  logic [4:0]  a_count;

  logic [31:0] b_addr, b_data, b_pc;
  logic [3:0]  b_ctrl;
  logic        b_rd_dv;
  logic [1:0]  b_state;
  logic [4:0]  b_count;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bus_trace_buffer #(.DEPTH(16), .POST_COUNT(8)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_bus_address(addr), .i_bus_data(data),
    .i_bus_DV(dv), .i_write_notread(we), .i_bhw(bhw), .i_PC(pc),
    .i_trig_en(trig_en), .i_trig_address(trig_addr), .i_rd_en(rd),
    .o_entry_address(a_addr), .o_entry_data(a_data), .o_entry_PC(a_pc),
    .o_entry_ctrl(a_ctrl), .o_rd_DV(a_rd_dv), .o_state(a_state), .o_count(a_count)
  );

  bus_trace_buffer #(.DEPTH(16), .POST_COUNT(0)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_bus_address(addr), .i_bus_data(data),
    .i_bus_DV(dv), .i_write_notread(we), .i_bhw(bhw), .i_PC(pc),
    .i_trig_en(trig_en), .i_trig_address(trig_addr), .i_rd_en(rd),
    .o_entry_address(b_addr), .o_entry_data(b_data), .o_entry_PC(b_pc),
    .o_entry_ctrl(b_ctrl), .o_rd_DV(b_rd_dv), .o_state(b_state), .o_count(b_count)
  );

  typedef struct {
    logic        rst;
    logic        dv;
    logic        trig_en;
    logic        rd;
    logic [31:0] addr;
    logic [1:0]  exp_state;
    logic [4:0]  exp_count;
    logic        exp_rd_dv;
  } vec_t;

  typedef struct {
    logic [31:0] address;
    logic [31:0] data;
    logic [3:0]  ctrl;
    logic [31:0] pc;
  } entry_t;

  vec_t   vecs[14];
  entry_t model[$];
  entry_t e;

  function automatic vec_t mk(logic r, logic d, logic t, logic rr, logic [31:0] a,
                              logic [1:0] s, logic [4:0] c, logic v);
    vec_t x;
    x.rst = r; x.dv = d; x.trig_en = t; x.rd = rr; x.addr = a;
    x.exp_state = s; x.exp_count = c; x.exp_rd_dv = v;
    return x;
  endfunction

  function automatic logic [31:0] exp_pc(logic [31:0] p);
`ifdef BUS_TRACE_PC_EN
    return p;
`else
    return (p & 32'h0);
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; dv = 1'b0; rd = 1'b0; trig_en = 1'b0; we = 1'b0; bhw = '0;
  endtask

  task automatic capture(input logic [31:0] a, input logic w, input logic [2:0] b);
    dv = 1'b1; addr = a; data = ~a; we = w; bhw = b; pc = 32'hDEADBEEF;
    model.push_back('{address: a, data: ~a, ctrl: {w, b}, pc: 32'hDEADBEEF});
    while (model.size() > 16) void'(model.pop_front());
  endtask

  initial begin
    // Reset, plain captures, ignored reads, trigger, mid-POST reset
    vecs[0]  = mk(1, 0, 0, 0, 32'h0,   2'd0, 5'd0, 0);
    vecs[1]  = mk(0, 1, 0, 0, 32'h100, 2'd0, 5'd1, 0);
    vecs[2]  = mk(0, 1, 0, 0, 32'h104, 2'd0, 5'd2, 0);
    vecs[3]  = mk(0, 1, 0, 0, 32'h108, 2'd0, 5'd3, 0);
    vecs[4]  = mk(0, 1, 0, 0, 32'h10C, 2'd0, 5'd4, 0);
    vecs[5]  = mk(0, 1, 0, 0, 32'h110, 2'd0, 5'd5, 0);
    vecs[6]  = mk(0, 0, 0, 1, 32'h0,   2'd0, 5'd5, 0);
    vecs[7]  = mk(0, 1, 1, 0, 32'h200, 2'd1, 5'd6, 0);
    vecs[8]  = mk(0, 1, 1, 0, 32'h204, 2'd1, 5'd7, 0);
    vecs[9]  = mk(0, 1, 1, 0, 32'h208, 2'd1, 5'd8, 0);
    vecs[10] = mk(0, 1, 1, 0, 32'h20C, 2'd1, 5'd9, 0);
    vecs[11] = mk(1, 1, 1, 1, 32'h200, 2'd0, 5'd0, 0);
    vecs[12] = mk(0, 0, 0, 1, 32'h0,   2'd0, 5'd0, 0);
    vecs[13] = mk(0, 1, 0, 0, 32'h300, 2'd0, 5'd1, 0);

    trig_addr = 32'h200;
    #2;
    for (int i = 0; i < 14; i++) begin
      rst = vecs[i].rst; dv = vecs[i].dv; trig_en = vecs[i].trig_en;
      rd = vecs[i].rd; addr = vecs[i].addr; data = ~vecs[i].addr;
      step();
      chk($sformatf("vec%0d state", i), 32'(a_state), 32'(vecs[i].exp_state));
      chk($sformatf("vec%0d count", i), 32'(a_count), 32'(vecs[i].exp_count));
      chk($sformatf("vec%0d rd_dv", i), 32'(a_rd_dv), 32'(vecs[i].exp_rd_dv));
    end

    // Wrap, trigger, 8 post captures, freeze
    idle(); rst = 1'b1; step(); idle();
    model.delete();
    trig_addr = 32'h8000_0000;
    trig_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      capture(32'(i * 4), 1'(i % 2), 3'(i % 8));
      step();
    end
    chk("wrap count", 32'(a_count), 32'd16);
    chk("wrap state", 32'(a_state), 32'd0);
    capture(32'h8000_0000, 1'b1, 3'd2);
    step();
    chk("trigger state", 32'(a_state), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      capture(32'h9000_0000 + 32'(k), 1'(k % 2), 3'(k % 8));
      step();
      chk($sformatf("post%0d state", k), 32'(a_state), (k < 8) ? 32'd1 : 32'd2);
    end
    chk("frozen count", 32'(a_count), 32'd16);

    // Trigger-matching DV while frozen: no capture, no state change
    dv = 1'b1; addr = 32'h8000_0000;
    step();
    chk("frozen dv state", 32'(a_state), 32'd2);
    chk("frozen dv count", 32'(a_count), 32'd16);
    chk("frozen dv rd_dv", 32'(a_rd_dv), 32'd0);
    idle();

    // Read-out oldest-first; first read collides with a DV
    for (int r = 0; r < 16; r++) begin
      rd = 1'b1;
      dv = (r == 0); addr = 32'hAAAA_0000; trig_en = 1'b0;
      step();
      e = model.pop_front();
      chk($sformatf("rd%0d rd_dv", r), 32'(a_rd_dv), 32'd1);
      chk($sformatf("rd%0d addr", r), a_addr, e.address);
      chk($sformatf("rd%0d data", r), a_data, e.data);
      chk($sformatf("rd%0d ctrl", r), 32'(a_ctrl), 32'(e.ctrl));
      chk($sformatf("rd%0d pc", r), a_pc, exp_pc(e.pc));
      chk($sformatf("rd%0d count", r), 32'(a_count), 32'(15 - r));
      if (r == 4) begin
        idle();
        step();
        chk("hold rd_dv", 32'(a_rd_dv), 32'd0);
        chk("hold addr", a_addr, e.address);
      end
    end
    chk("last entry", a_addr, 32'h9000_0008);
    chk("rearmed state", 32'(a_state), 32'd0);
    rd = 1'b1; dv = 1'b0;
    step();
    chk("empty read rd_dv", 32'(a_rd_dv), 32'd0);
    chk("empty read count", 32'(a_count), 32'd0);
    chk("empty read holds", a_addr, 32'h9000_0008);
    idle();

    // POST_COUNT=0 instance: freeze on the trigger edge itself
    rst = 1'b1; step(); idle();
    trig_addr = 32'h1234; trig_en = 1'b1;
    dv = 1'b1; addr = 32'h1234; data = 32'h5555_AAAA; we = 1'b1; bhw = 3'd5; pc = 32'hDEADBEEF;
    step();
    idle();
    chk("pc0 state", 32'(b_state), 32'd2);
    chk("pc0 count", 32'(b_count), 32'd1);
    rd = 1'b1;
    step();
    idle();
    chk("pc0 rd_dv", 32'(b_rd_dv), 32'd1);
    chk("pc0 addr", b_addr, 32'h1234);
    chk("pc0 data", b_data, 32'h5555_AAAA);
    chk("pc0 ctrl", 32'(b_ctrl), 32'hD);
    chk("pc0 pc", b_pc, exp_pc(32'hDEADBEEF));
    chk("pc0 rearm", 32'(b_state), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
